// File: rtl/bytes_to_bits_stream_if.sv
// ----------------------------------------------------------------------------
// bytes_to_bits_stream_if
// Purpose : bundles the byte-side and bit-side streaming handshakes of
//           bytes_to_bits_stream.
// Handshake: a transfer happens on a rising clock edge where valid && ready
//           are both high. A source holds valid and its payload steady until
//           that transfer happens. ready may depend only on the receiver's
//           registered state, never combinationally on valid.
// Signals :
//   in_valid  / in_ready  / in_data   byte beats into the unpacker
//   out_valid / out_ready / out_data  bit chunks out of the unpacker
//   out_last                          marks the final chunk of a message
// Modports: slave  - the unpacker (consumes bytes, produces chunks)
//           master - the environment (produces bytes, consumes chunks)
// ----------------------------------------------------------------------------
interface bytes_to_bits_stream_if #(
    parameter int IN_BYTES = 1,
    parameter int OUT_W    = 4
);
    logic                    in_valid;
    logic                    in_ready;
    logic [8*IN_BYTES-1:0]   in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [OUT_W-1:0]        out_data;
    logic                    out_last;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/bytes_to_bits_stream.sv
// ----------------------------------------------------------------------------
// bytes_to_bits_stream
// Purpose : streaming byte-to-bit unpacker. Accepts IN_BYTES bytes per beat
//           and emits OUT_W-bit chunks, LSB-first, for a message of len bytes.
// Config  : define BYTES_TO_BITS_STREAM_PAD_EN to emit leftover tail bits
//           (fewer than OUT_W) as a final zero-padded chunk; otherwise they
//           are discarded and out_last rides on the last full chunk.
// Ports   :
//   clk      in   clock, rising edge
//   rst_n    in   synchronous reset, active low
//   start    in   pulse, latches len, honoured only in IDLE
//   len      in   message length in bytes (0..MAX_LEN)
//   s        if   slave side of bytes_to_bits_stream_if (byte in, chunk out)
//   busy     out  high from start accept until the done cycle inclusive
//   done     out  one-cycle pulse when the message has finished
//   o_state  out  FSM state for observation (0 IDLE, 1 RUN, 2 DONE)
// ----------------------------------------------------------------------------
module bytes_to_bits_stream #(
    parameter  int IN_BYTES = 1,
    parameter  int OUT_W    = 4,
    parameter  int MAX_LEN  = 384,
    localparam int LEN_W    = $clog2(MAX_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [LEN_W-1:0]     len,
    bytes_to_bits_stream_if.slave s,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           o_state
);
    localparam int IN_W  = 8 * IN_BYTES;
    localparam int BUF_W = IN_W + OUT_W;
    localparam int CNT_W = $clog2(BUF_W + 1);

    localparam logic [CNT_W-1:0] C_OUT_W     = CNT_W'(OUT_W);
    localparam logic [CNT_W-1:0] C_TWO_OUT_W = CNT_W'(2 * OUT_W);
    localparam logic [LEN_W-1:0] C_IN_BYTES  = LEN_W'(IN_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [BUF_W-1:0]   r_buf;        // bit 0 is the oldest bit held
    logic [CNT_W-1:0]   r_cnt;        // number of valid bits in r_buf
    logic [LEN_W-1:0]   r_bytes_rem;  // bytes still to be accepted

    logic               w_run;
    logic               w_rem_zero;
    logic               w_out_valid;
    logic               w_out_last;
    logic               w_in_ready;
    logic               w_fire;
    logic               w_accept;
    logic               w_starve;
    logic [LEN_W-1:0]   w_nb;
    logic [IN_W-1:0]    w_in_masked;
    logic [BUF_W-1:0]   w_buf_s;
    logic [CNT_W-1:0]   w_cnt_s;
    logic [BUF_W-1:0]   w_buf_n;
    logic [CNT_W-1:0]   w_cnt_n;

    assign w_run      = (r_state == ST_RUN);
    assign w_rem_zero = (r_bytes_rem == '0);

`ifdef BYTES_TO_BITS_STREAM_PAD_EN
    // A short tail (0 < cnt < OUT_W) after the last byte is still emitted.
    assign w_out_valid = w_run && ((r_cnt >= C_OUT_W) ||
                                   (w_rem_zero && (r_cnt != '0)));
    assign w_out_last  = w_out_valid && w_rem_zero && (r_cnt <= C_OUT_W);
    assign w_starve    = 1'b0;
`else
    // Only full chunks leave; the message ends once fewer than OUT_W bits
    // remain and no more bytes are due.
    assign w_out_valid = w_run && (r_cnt >= C_OUT_W);
    assign w_out_last  = w_out_valid && w_rem_zero && (r_cnt < C_TWO_OUT_W);
    assign w_starve    = w_run && w_rem_zero && (r_cnt < C_OUT_W);
`endif

    // Space for a full beat is guaranteed once at most OUT_W bits are held.
    assign w_in_ready = w_run && !w_rem_zero && (r_cnt <= C_OUT_W);
    assign w_fire     = w_out_valid && s.out_ready;
    assign w_accept   = s.in_valid && w_in_ready;

    always_comb begin
        w_nb        = (r_bytes_rem < C_IN_BYTES) ? r_bytes_rem : C_IN_BYTES;
        w_in_masked = '0;
        for (int k = 0; k < IN_BYTES; k++) begin
            if (LEN_W'(k) < w_nb) begin
                w_in_masked[8*k +: 8] = s.in_data[8*k +: 8];
            end
        end

        // Drain first, then append behind whatever is left.
        w_buf_s = r_buf;
        w_cnt_s = r_cnt;
        if (w_fire) begin
            w_buf_s = r_buf >> OUT_W;
            w_cnt_s = (r_cnt >= C_OUT_W) ? (r_cnt - C_OUT_W) : '0;
        end

        w_buf_n = w_buf_s;
        w_cnt_n = w_cnt_s;
        if (w_accept) begin
            w_buf_n = w_buf_s | ({{OUT_W{1'b0}}, w_in_masked} << w_cnt_s);
            w_cnt_n = w_cnt_s + CNT_W'({w_nb, 3'b000});
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_buf       <= '0;
            r_cnt       <= '0;
            r_bytes_rem <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_buf       <= '0;
                        r_cnt       <= '0;
                        r_bytes_rem <= len;
                        r_state     <= (len == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_buf <= w_buf_n;
                    r_cnt <= w_cnt_n;
                    if (w_accept) begin
                        r_bytes_rem <= r_bytes_rem - w_nb;
                    end
                    // Leaving RUN clears any discarded tail so out_data reads 0.
                    if ((w_fire && w_out_last) || w_starve) begin
                        r_state <= ST_DONE;
                        r_buf   <= '0;
                        r_cnt   <= '0;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign s.in_ready  = w_in_ready;
    assign s.out_valid = w_out_valid;
    assign s.out_data  = r_buf[OUT_W-1:0];
    assign s.out_last  = w_out_last;
    assign busy        = (r_state != ST_IDLE);
    assign done        = (r_state == ST_DONE);
    assign o_state     = r_state;
endmodule

// File: tb/tb_bytes_to_bits_stream.sv
module tb_bytes_to_bits_stream;
    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // ---------------- shared stimulus ----------------
    logic [1:0]  sel = 2'd0;   // 0: IN1/OUT4, 1: IN1/OUT3, 2: IN2/OUT8
    logic        start;
    logic [8:0]  len;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] in_data;

    logic start_a, start_b, start_c;
    assign start_a = start && (sel == 2'd0);
    assign start_b = start && (sel == 2'd1);
    assign start_c = start && (sel == 2'd2);

    bytes_to_bits_stream_if #(.IN_BYTES(1), .OUT_W(4)) if_a ();
    bytes_to_bits_stream_if #(.IN_BYTES(1), .OUT_W(3)) if_b ();
    bytes_to_bits_stream_if #(.IN_BYTES(2), .OUT_W(8)) if_c ();

    assign if_a.in_valid  = in_valid;
    assign if_a.in_data   = in_data[7:0];
    assign if_a.out_ready = out_ready;
    assign if_b.in_valid  = in_valid;
    assign if_b.in_data   = in_data[7:0];
    assign if_b.out_ready = out_ready;
    assign if_c.in_valid  = in_valid;
    assign if_c.in_data   = in_data;
    assign if_c.out_ready = out_ready;

    logic busy_a, busy_b, busy_c, done_a, done_b, done_c;
    logic [1:0] st_a, st_b, st_c;

    bytes_to_bits_stream #(.IN_BYTES(1), .OUT_W(4), .MAX_LEN(384)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .len(len), .s(if_a),
        .busy(busy_a), .done(done_a), .o_state(st_a));
    bytes_to_bits_stream #(.IN_BYTES(1), .OUT_W(3), .MAX_LEN(384)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .len(len), .s(if_b),
        .busy(busy_b), .done(done_b), .o_state(st_b));
    bytes_to_bits_stream #(.IN_BYTES(2), .OUT_W(8), .MAX_LEN(384)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .len(len), .s(if_c),
        .busy(busy_c), .done(done_c), .o_state(st_c));

    // Observation mux for the selected instance
    logic       ob_in_ready, ob_out_valid, ob_out_last, ob_busy, ob_done;
    logic [7:0] ob_out_data;
    always_comb begin
        ob_in_ready  = if_a.in_ready;
        ob_out_valid = if_a.out_valid;
        ob_out_last  = if_a.out_last;
        ob_out_data  = {4'b0, if_a.out_data};
        ob_busy      = busy_a;
        ob_done      = done_a;
        case (sel)
            2'd1: begin
                ob_in_ready  = if_b.in_ready;
                ob_out_valid = if_b.out_valid;
                ob_out_last  = if_b.out_last;
                ob_out_data  = {5'b0, if_b.out_data};
                ob_busy      = busy_b;
                ob_done      = done_b;
            end
            2'd2: begin
                ob_in_ready  = if_c.in_ready;
                ob_out_valid = if_c.out_valid;
                ob_out_last  = if_c.out_last;
                ob_out_data  = if_c.out_data;
                ob_busy      = busy_c;
                ob_done      = done_c;
            end
            default: ;
        endcase
    end

    // ---------------- scoreboard state ----------------
    int         checks = 0;
    int         errors = 0;
    logic [7:0] src [0:383];
    logic [7:0] got_q [$];
    bit         last_q [$];
    logic [7:0] exp_q [$];
    int         last_fire_cyc, done_cyc, first_acc_cyc, first_val_cyc, busy_cnt;

    // ---------------- driver ----------------
    // Runs one message on instance s; p_in / p_out are stall percentages.
    task automatic run_msg(input logic [1:0] s, input int n, input int p_in, input int p_out);
        int idx, cyc, ib;
        bit fin, stalled, hold_l;
        logic [7:0] hold_d;
        ib = (s == 2'd2) ? 2 : 1;
        sel = s;
        got_q.delete();
        last_q.delete();
        last_fire_cyc = -1; done_cyc = -1; first_acc_cyc = -1; first_val_cyc = -1;
        busy_cnt = 0; idx = 0; cyc = 0; fin = 0; stalled = 0; hold_l = 0; hold_d = '0;
        @(negedge clk);
        len   = 9'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!fin && cyc < 20000) begin
            if (ob_busy) busy_cnt++;
            if (ob_done) begin
                done_cyc = cyc;
                fin = 1;
            end
            if (stalled) begin
                checks++;
                if (ob_out_valid !== 1'b1 || ob_out_data !== hold_d || ob_out_last !== hold_l) begin
                    errors++;
                    $display("FAIL stall_stable cyc=%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                             cyc, ob_out_valid, ob_out_data, ob_out_last, hold_d, hold_l);
                end
            end
            in_valid  = (idx < n) && ($urandom_range(99) >= p_in);
            in_data   = {src[(idx + 1) % 384], src[idx % 384]};
            out_ready = ($urandom_range(99) >= p_out);
            if (in_valid && ob_in_ready) begin
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
                idx += ((n - idx) < ib) ? (n - idx) : ib;
            end
            if (ob_out_valid && first_val_cyc < 0) first_val_cyc = cyc;
            stalled = ob_out_valid && !out_ready;
            hold_d  = ob_out_data;
            hold_l  = ob_out_last;
            if (ob_out_valid && out_ready) begin
                got_q.push_back(ob_out_data);
                last_q.push_back(ob_out_last);
                if (ob_out_last) last_fire_cyc = cyc;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL timeout sel=%0d got no done after %0d cycles, want done", s, cyc);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #1;
            checks++;
            if ({ob_in_ready, ob_out_valid, ob_out_last, ob_out_data, ob_busy, ob_done} !== 13'd0) begin
                errors++;
                $display("FAIL reset_outputs sel=%0d got %b want 0", s,
                         {ob_in_ready, ob_out_valid, ob_out_last, ob_out_data, ob_busy, ob_done});
            end
        end
        checks++;
        if (st_a !== 2'd0) begin
            errors++;
            $display("FAIL reset_state got %0d want 0", st_a);
        end
        sel = 2'd0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Chunk list compare against exp_q, last only on the final chunk.
    task automatic test_basic();
        src[0] = 8'hA5; src[1] = 8'h3C;
        exp_q = '{8'h5, 8'hA, 8'hC, 8'h3};
        run_msg(2'd0, 2, 0, 0);
        checks++;
        if (got_q.size() != 4) begin
            errors++;
            $display("FAIL basic_count got %0d want 4", got_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_q[i] !== exp_q[i] || last_q[i] !== (i == 3)) begin
                    errors++;
                    $display("FAIL basic_chunk%0d got %h/%b want %h/%b", i, got_q[i], last_q[i], exp_q[i], i == 3);
                end
            end
        end
        checks++;
        if (done_cyc - last_fire_cyc != 1) begin
            errors++;
            $display("FAIL basic_done_lat got %0d want 1", done_cyc - last_fire_cyc);
        end
        checks++;
        if (first_val_cyc - first_acc_cyc != 1) begin
            errors++;
            $display("FAIL basic_first_lat got %0d want 1", first_val_cyc - first_acc_cyc);
        end
    endtask

    task automatic test_tail();
        int nexp;
        src[0] = 8'hFF;
`ifdef BYTES_TO_BITS_STREAM_PAD_EN
        exp_q = '{8'h7, 8'h7, 8'h3};
`else
        exp_q = '{8'h7, 8'h7};
`endif
        nexp = exp_q.size();
        run_msg(2'd1, 1, 0, 0);
        checks++;
        if (got_q.size() != nexp) begin
            errors++;
            $display("FAIL tail_count got %0d want %0d", got_q.size(), nexp);
        end else begin
            for (int i = 0; i < nexp; i++) begin
                checks++;
                if (got_q[i] !== exp_q[i] || last_q[i] !== (i == nexp - 1)) begin
                    errors++;
                    $display("FAIL tail_chunk%0d got %h/%b want %h/%b", i, got_q[i], last_q[i], exp_q[i], i == nexp - 1);
                end
            end
        end
    endtask

    task automatic test_multibyte();
        src[0] = 8'h11; src[1] = 8'h22; src[2] = 8'h33; src[3] = 8'hFF;
        exp_q = '{8'h11, 8'h22, 8'h33};
        run_msg(2'd2, 3, 0, 0);
        checks++;
        if (got_q.size() != 3) begin
            errors++;
            $display("FAIL multibyte_count got %0d want 3", got_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got_q[i] !== exp_q[i] || last_q[i] !== (i == 2)) begin
                    errors++;
                    $display("FAIL multibyte_chunk%0d got %h/%b want %h/%b", i, got_q[i], last_q[i], exp_q[i], i == 2);
                end
            end
        end
    endtask

    task automatic test_zero_len();
        run_msg(2'd0, 0, 0, 0);
        checks++;
        if (got_q.size() != 0 || done_cyc != 0 || busy_cnt != 1) begin
            errors++;
            $display("FAIL zero_len got chunks=%0d done_cyc=%0d busy=%0d want 0/0/1",
                     got_q.size(), done_cyc, busy_cnt);
        end
        checks++;
        if (ob_busy !== 1'b0 || ob_done !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_after got busy=%b done=%b want 0/0", ob_busy, ob_done);
        end
    endtask

    task automatic test_back_to_back();
        src[0] = 8'h96;
        for (int r = 0; r < 2; r++) begin
            run_msg(2'd0, 1, 0, 0);
            checks++;
            if (got_q.size() != 2 || got_q[0] !== 8'h6 || got_q[1] !== 8'h9 ||
                last_q[0] !== 1'b0 || last_q[1] !== 1'b1) begin
                errors++;
                $display("FAIL b2b_run%0d got n=%0d want 6,9(last)", r, got_q.size());
            end
        end
    endtask

    task automatic test_random_stall();
        for (int i = 0; i < 384; i++) src[i] = 8'($urandom_range(255));
        exp_q.delete();
        for (int i = 0; i < 384; i++) begin
            exp_q.push_back({4'b0, src[i][3:0]});
            exp_q.push_back({4'b0, src[i][7:4]});
        end
        run_msg(2'd0, 384, 30, 40);
        checks++;
        if (got_q.size() != 768) begin
            errors++;
            $display("FAIL random_count got %0d want 768", got_q.size());
        end else begin
            for (int i = 0; i < 768; i++) begin
                checks++;
                if (got_q[i] !== exp_q[i] || last_q[i] !== (i == 767)) begin
                    errors++;
                    $display("FAIL random_chunk%0d got %h/%b want %h/%b", i, got_q[i], last_q[i], exp_q[i], i == 767);
                end
            end
        end
    endtask

    task automatic test_abort();
        int seen_valid;
        sel = 2'd0;
        for (int i = 0; i < 384; i++) src[i] = 8'(i * 7 + 1);
        @(negedge clk);
        len = 9'd384; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_data = {8'h00, src[i]}; in_valid = 1'b1; out_ready = 1'b1;
            @(negedge clk);
        end
        len = 9'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (st_a !== 2'd1 || ob_busy !== 1'b1 || ob_done !== 1'b0) begin
            errors++;
            $display("FAIL stray_start got st=%0d busy=%b done=%b want 1/1/0", st_a, ob_busy, ob_done);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({ob_in_ready, ob_out_valid, ob_out_last, ob_out_data, ob_busy, ob_done} !== 13'd0 || st_a !== 2'd0) begin
            errors++;
            $display("FAIL abort_reset got %b st=%0d want 0",
                     {ob_in_ready, ob_out_valid, ob_out_last, ob_out_data, ob_busy, ob_done}, st_a);
        end
        rst_n = 1'b1;
        seen_valid = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ob_out_valid || ob_busy) seen_valid++;
        end
        checks++;
        if (seen_valid != 0) begin
            errors++;
            $display("FAIL abort_residual got %0d active cycles want 0", seen_valid);
        end
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_basic();
        test_tail();
        test_multibyte();
        test_zero_len();
        test_back_to_back();
        test_random_stall();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
